// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit with architectural HI/LO registers.
//
// A multiply takes one shift-add step per clock. A divide takes one restoring
// step per clock. Every operation lasts WIDTH clocks after the start edge.
// Signed ops run on operand magnitudes, and the signs are fixed up on the
// last iteration edge. HI/LO keep their previous contents during RUN. They
// change only when a result lands or when mthi/mtlo write while the unit is idle.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   start      request a new operation (sampled only while idle)
//   op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   operand_a  multiplicand / dividend
//   operand_b  multiplier / divisor
//   hi_we      mthi write enable (idle only)
//   lo_we      mtlo write enable (idle only)
//   wdata      mthi/mtlo write data
//   hi         HI register (product upper half / remainder)
//   lo         LO register (product lower half / quotient)
//   busy       operation in progress
//   done       one-cycle pulse when hi/lo take a new result
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; mthi/mtlo writes accepted
// S_RUN  | iterating; counter counts WIDTH..1, result lands when it hits 1

module md_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state;
   logic [CW-1:0]    cnt;
   logic             is_div_q;
   logic             neg_q;       // negate product / quotient
   logic             rem_neg_q;   // negate remainder (dividend was negative)
   logic             div0_q;
   logic [WIDTH-1:0] a_raw_q;
   logic [WIDTH-1:0] mcand_q;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc_q;       // product upper half / partial remainder
   logic [WIDTH-1:0] mq_q;        // multiplier -> product low / dividend -> quotient
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             done_q;

   // Start-edge operand conditioning; sign flags are forced low for unsigned ops.
   logic             a_sgn;
   logic             b_sgn;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   assign a_sgn = op[0] & operand_a[WIDTH-1];
   assign b_sgn = op[0] & operand_b[WIDTH-1];
   assign a_mag = a_sgn ? (~operand_a + 1'b1) : operand_a;
   assign b_mag = b_sgn ? (~operand_b + 1'b1) : operand_b;

   // One iteration step.
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [WIDTH-1:0]   nxt_acc;
   logic [WIDTH-1:0]   nxt_mq;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   assign div_shift = {acc_q, mq_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, mcand_q};

   always_comb begin
      nxt_acc = acc_q;
      nxt_mq  = mq_q;
      if (is_div_q) begin
         // A clear top bit of the difference means the divisor fits, so keep the subtraction.
         if (!div_diff[WIDTH]) begin
            nxt_acc = div_diff[WIDTH-1:0];
            nxt_mq  = {mq_q[WIDTH-2:0], 1'b1};
         end else begin
            nxt_acc = div_shift[WIDTH-1:0];
            nxt_mq  = {mq_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         nxt_acc = mul_sum[WIDTH:1];
         nxt_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
      end
   end

   assign prod     = {nxt_acc, nxt_mq};
   assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
   assign quo_fix  = neg_q ? (~nxt_mq + 1'b1) : nxt_mq;
   assign rem_fix  = rem_neg_q ? (~nxt_acc + 1'b1) : nxt_acc;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         div0_q    <= 1'b0;
         a_raw_q   <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (hi_we) hi_q <= wdata;
               if (lo_we) lo_q <= wdata;
               if (start) begin
                  state     <= S_RUN;
                  cnt       <= CW'(WIDTH);
                  is_div_q  <= op[1];
                  neg_q     <= a_sgn ^ b_sgn;
                  rem_neg_q <= a_sgn;
                  div0_q    <= op[1] & (operand_b == '0);
                  a_raw_q   <= operand_a;
                  mcand_q   <= op[1] ? b_mag : a_mag;
                  mq_q      <= op[1] ? a_mag : b_mag;
                  acc_q     <= '0;
               end
            end
            S_RUN: begin
               acc_q <= nxt_acc;
               mq_q  <= nxt_mq;
               cnt   <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state  <= S_IDLE;
                  done_q <= 1'b1;
                  if (!is_div_q) begin
                     hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                     lo_q <= prod_fix[WIDTH-1:0];
                  end else if (div0_q) begin
                     hi_q <= a_raw_q;
                     lo_q <= '1;
                  end else begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state == S_RUN);
   assign done = done_q;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit. Directed vectors push their hand-computed HI/LO into
// a scoreboard queue. A monitor pops one entry on every done pulse and
// compares it. Inline checks cover reset, busy timing and the mthi/mtlo paths.

module tb_md_unit;

   localparam logic [1:0] MULTU = 2'b00;
   localparam logic [1:0] MULT  = 2'b01;
   localparam logic [1:0] DIVU  = 2'b10;
   localparam logic [1:0] DIV   = 2'b11;

   logic        clock;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   md_unit #(.WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .hi_we     (hi_we),
      .lo_we     (lo_we),
      .wdata     (wdata),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      int          id;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_bad = 0;
   int   vid   = 0;

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (done === 1'b1) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_done got hi=%h lo=%h, no result expected", hi, lo);
         end else begin
            mon_e = sb.pop_front();
            if (hi !== mon_e.hi || lo !== mon_e.lo) begin
               n_bad++;
               $display("FAIL vec%0d got hi=%h lo=%h expected hi=%h lo=%h",
                        mon_e.id, hi, lo, mon_e.hi, mon_e.lo);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
   endtask

   // Drive start at the current negedge, then return at the negedge after E0.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit push);
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      if (push) sb.push_back('{id: vid, hi: eh, lo: el});
      vid++;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Count busy cycles until busy drops (bounded); done must be high there.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         cyc++;
         @(negedge clock);
      end
      check("done_pulse", {63'b0, done}, 64'd1);
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el);
      int c;
      issue(o, a, b, eh, el, 1'b1);
      check("accepted_busy", {63'b0, busy}, 64'd1);
      wait_done(c);
      check("latency", 64'(c), 64'd32);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int  c;
      bit  seen;
      clock     = 1'b0;
      reset     = 1'b1;
      start     = 1'b0;
      op        = 2'b00;
      operand_a = '0;
      operand_b = '0;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      wdata     = '0;

      repeat (3) @(negedge clock);
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_busy_done", {62'b0, busy, done}, 64'd0);
      reset = 1'b0;
      @(negedge clock);

      // First op: exact busy width and a single done pulse.
      issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
      wait_done(c);
      check("busy_cycles", 64'(c), 64'd32);
      @(negedge clock);
      check("done_once", {63'b0, done}, 64'd0);

      // Back-to-back: each new start lands on the previous op's done cycle.
      run(MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run(DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run(DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
      run(DIV,   32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
      @(negedge clock);

      // Mid-RUN start and mthi are ignored; HI/LO hold the previous result.
      issue(DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b1);
      start     = 1'b1;
      op        = MULTU;
      operand_a = 32'd5;
      operand_b = 32'd5;
      hi_we     = 1'b1;
      wdata     = 32'hDEAD_BEEF;
      repeat (3) @(negedge clock);
      start = 1'b0;
      hi_we = 1'b0;
      check("run_hold_hilo", {hi, lo}, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
      check("run_busy", {63'b0, busy}, 64'd1);
      wait_done(c);
      check("run_latency", 64'(c), 64'd29);
      @(negedge clock);
      check("no_restart", {62'b0, busy, done}, 64'd0);

      // Idle mtlo, then mthi+mtlo together.
      lo_we = 1'b1;
      wdata = 32'h0000_0055;
      @(negedge clock);
      lo_we = 1'b0;
      check("idle_mtlo", {hi, lo}, {32'h0000_0002, 32'h0000_0055});
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hA5A5_A5A5;
      @(negedge clock);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("idle_mthi_mtlo", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});

      // mthi on the start edge lands at E0; the result overwrites it later.
      hi_we = 1'b1;
      wdata = 32'h1234_5678;
      issue(MULTU, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b1);
      hi_we = 1'b0;
      check("write_at_e0", {hi, lo}, {32'h1234_5678, 32'hA5A5_A5A5});
      wait_done(c);
      check("write_at_e0_latency", 64'(c), 64'd32);

      // Reset at iteration 10 abandons the op without a done pulse.
      issue(MULTU, 32'h0000_1234, 32'h0000_5678, 32'h0, 32'h0, 1'b0);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_hilo", {hi, lo}, 64'd0);
      check("abort_busy_done", {62'b0, busy, done}, 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (done === 1'b1) seen = 1'b1;
      end
      check("abort_no_done", {63'b0, seen}, 64'd0);
      run(MULTU, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A);

      repeat (3) @(negedge clock);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
